set_assoc_cache: RTL

Parametrised, trace-driven, tag-only set-associative cache model with a valid/ready request handshake, true-LRU replacement, a modelled miss penalty and saturating hit/miss statistics. It is the successor to the fixed direct-mapped/two-level drivers. Ways, sets, block size and miss latency are all generic, and WAYS=1 reproduces direct-mapped behaviour. It sits between an address-trace source (testbench file reader or upstream core model) and the statistics/VCD dump logic.

---
 rtl/set_assoc_cache_if.sv | 22 ++
 rtl/set_assoc_cache.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_if.sv
// Request/response handshake between an address-trace source and the
// set-associative cache model.
//   req_valid  : source has an address to look up
//   req_ready  : cache can accept a request this cycle
//   address    : byte address, sampled on accept
//   resp_valid : one-cycle pulse, lookup result ready
//   resp_hit   : qualified by resp_valid, 1 = hit, 0 = miss
// master = trace source, slave = cache.
interface set_assoc_cache_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] address;
    logic              resp_valid;
    logic              resp_hit;

    modport master (output req_valid, output address,
                    input  req_ready, input  resp_valid, input resp_hit);
    modport slave  (input  req_valid, input  address,
                    output req_ready, output resp_valid, output resp_hit);
endinterface

// File: rtl/set_assoc_cache.sv
// Tag-only set-associative cache model with true-LRU replacement, a fixed
// miss penalty and saturating hit/miss statistics. WAYS=1 behaves as a
// direct-mapped cache.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request/response handshake (slave side)
//   flush      : invalidate all lines, acted on in IDLE only
//   clr_stats  : zero both counters (wins over a same-edge increment)
//   Hitcount   : saturating hit counter
//   Misscount  : saturating miss counter
//
// state  | meaning
// IDLE   | waiting for a request or a flush
// LOOKUP | tag compare against the indexed set
// REFILL | modelled miss penalty, line installed on the final cycle
module set_assoc_cache #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 4,
    parameter int WAYS     = 2,
    parameter int MISS_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    set_assoc_cache_if.slave  bus,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  Hitcount,
    output logic [CNT_W-1:0]  Misscount
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    // A single way needs no age; a 1-bit constant-zero field keeps the code uniform.
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LAT_W = $clog2(MISS_LAT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT_W-1:0]  refill_cnt;

    logic              valid_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic               hit;
    logic [AGE_W-1:0]   hit_way;
    logic [AGE_W-1:0]   vic_way;
    logic [AGE_W-1:0]   touch_way;
    logic [AGE_W-1:0]   new_age [WAYS];

    assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx = addr_q[OFFSET_W +: INDEX_W];

    assign bus.req_ready = (state == IDLE) && !flush && !rst;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        // Oldest way first, then overridden by the lowest-numbered invalid way.
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) begin
                vic_way = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                vic_way = AGE_W'(w);
            end
        end
        touch_way = (state == LOOKUP) ? hit_way : vic_way;
        for (int w = 0; w < WAYS; w++) begin
            new_age[w] = age_q[req_idx][w];
            if (AGE_W'(w) == touch_way) begin
                new_age[w] = '0;
            end else if (age_q[req_idx][w] < age_q[req_idx][touch_way]) begin
                new_age[w] = age_q[req_idx][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            refill_cnt     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            for (int w = 0; w < WAYS; w++) begin
                                valid_q[s][w] <= 1'b0;
                                age_q[s][w]   <= AGE_W'(w);
                            end
                        end
                    end else if (bus.req_valid) begin
                        addr_q <= bus.address;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_hit   <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[req_idx][w] <= new_age[w];
                        end
                        state <= IDLE;
                    end else begin
                        refill_cnt <= LAT_W'(MISS_LAT);
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_cnt == LAT_W'(1)) begin
                        valid_q[req_idx][vic_way] <= 1'b1;
                        tag_q[req_idx][vic_way]   <= req_tag;
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[req_idx][w] <= new_age[w];
                        end
                        bus.resp_valid <= 1'b1;
                        bus.resp_hit   <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        refill_cnt <= refill_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            Hitcount  <= '0;
            Misscount <= '0;
        end else if (state == LOOKUP) begin
            if (hit && (Hitcount != '1)) begin
                Hitcount <= Hitcount + 1'b1;
            end
            if (!hit && (Misscount != '1)) begin
                Misscount <= Misscount + 1'b1;
            end
        end
    end
endmodule
